// File: rtl/riscboy_ppu_pixel_unpack.sv
// Pixel unpacker: pairs AGU pixel metadata with returned bus halfwords,
// extracts the addressed pixel for the current span's pixel mode and
// presents one pixel per handshake to the palette/blend stage.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   span_start, span_pixmode        latch pixel mode (only while idle)
//   bus_data_vld, bus_data          returned read data (no backpressure)
//   pinfo_u, pinfo_discard,
//   pinfo_vld, pinfo_rdy            pixel metadata from the AGU
//   pixel_data, pixel_paletted,
//   pixel_discard, pixel_vld,
//   pixel_rdy                       pixel output handshake
//   idle                            data buffer and output register empty
module riscboy_ppu_pixel_unpack #(
    parameter int unsigned W_DATA          = 16,
    parameter int unsigned DATA_FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              span_start,
    input  logic [1:0]        span_pixmode,

    input  logic              bus_data_vld,
    input  logic [W_DATA-1:0] bus_data,

    input  logic [3:0]        pinfo_u,
    input  logic              pinfo_discard,
    input  logic              pinfo_vld,
    output logic              pinfo_rdy,

    output logic [W_DATA-1:0] pixel_data,
    output logic              pixel_paletted,
    output logic              pixel_discard,
    output logic              pixel_vld,
    input  logic              pixel_rdy,

    output logic              idle
);

    localparam int unsigned W_PTR   = (DATA_FIFO_DEPTH > 1) ? $clog2(DATA_FIFO_DEPTH) : 1;
    localparam int unsigned W_LEVEL = $clog2(DATA_FIFO_DEPTH + 1);
    localparam logic [W_PTR-1:0]   PTR_LAST   = W_PTR'(DATA_FIFO_DEPTH - 1);
    localparam logic [W_LEVEL-1:0] LEVEL_FULL = W_LEVEL'(DATA_FIFO_DEPTH);

    logic [1:0]        pixmode;
    logic [W_DATA-1:0] fifo_mem [DATA_FIFO_DEPTH];
    logic [W_PTR-1:0]  wr_ptr;
    logic [W_PTR-1:0]  rd_ptr;
    logic [W_LEVEL-1:0] level;
    logic              data_empty;
    logic              data_full;
    logic              data_push;
    logic              data_pop;
    logic              take;
    logic [W_DATA-1:0] head;
    logic [W_DATA-1:0] unpacked;

    // Pixel mode for the current span
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixmode <= 2'd0;
        end else if (span_start) begin
            pixmode <= span_pixmode;
        end
    end

    // Handshake and FIFO control
    always_comb begin
        data_empty = (level == '0);
        data_full  = (level == LEVEL_FULL);
        take       = pinfo_vld && (pinfo_discard || !data_empty) && (!pixel_vld || pixel_rdy);
        data_pop   = take && !pinfo_discard;
        // A write while full is only accepted if the head leaves in the same cycle
        data_push  = bus_data_vld && (!data_full || data_pop);
        pinfo_rdy  = take;
        idle       = data_empty && !pixel_vld;
        head       = fifo_mem[rd_ptr];
    end

    // Returned-data storage; contents need no reset
    always_ff @(posedge clk) begin
        if (data_push) begin
            fifo_mem[wr_ptr] <= bus_data;
        end
    end

    // Returned-data pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (data_push) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + W_PTR'(1);
            end
            if (data_pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + W_PTR'(1);
            end
            case ({data_push, data_pop})
                2'b10:   level <= level + W_LEVEL'(1);
                2'b01:   level <= level - W_LEVEL'(1);
                default: level <= level;
            endcase
        end
    end

    // Little-endian pixel extraction from the FIFO head
    always_comb begin
        unpacked = head;
        case (pixmode)
            2'd1:    unpacked = W_DATA'(head[{pinfo_u[0], 3'b000} +: 8]);
            2'd2:    unpacked = W_DATA'(head[{pinfo_u[1:0], 2'b00} +: 4]);
            2'd3:    unpacked = W_DATA'(head[pinfo_u]);
            default: unpacked = head;
        endcase
    end

    // Output register, held while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_vld      <= 1'b0;
            pixel_data     <= '0;
            pixel_paletted <= 1'b0;
            pixel_discard  <= 1'b0;
        end else if (take) begin
            pixel_vld      <= 1'b1;
            pixel_data     <= pinfo_discard ? '0 : unpacked;
            pixel_paletted <= (pixmode != 2'd0);
            pixel_discard  <= pinfo_discard;
        end else if (pixel_rdy) begin
            pixel_vld      <= 1'b0;
        end
    end

    // Bus data cannot be stalled, so arriving at a full buffer loses data
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(bus_data_vld && data_full && !data_pop));

    a_span_start_idle: assert property (@(posedge clk) disable iff (!rst_n)
        span_start |-> idle);

endmodule

// File: tb/tb_riscboy_ppu_pixel_unpack.sv
// Testbench for riscboy_ppu_pixel_unpack: queue-driven pinfo/bus stimulus,
// output pixels collected and compared against a specification-level model.
module tb_riscboy_ppu_pixel_unpack;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        span_start;
    logic [1:0]  span_pixmode;
    logic        bus_data_vld;
    logic [15:0] bus_data;
    logic [3:0]  pinfo_u;
    logic        pinfo_discard;
    logic        pinfo_vld;
    logic        pinfo_rdy;
    logic [15:0] pixel_data;
    logic        pixel_paletted;
    logic        pixel_discard;
    logic        pixel_vld;
    logic        pixel_rdy;
    logic        idle;

    riscboy_ppu_pixel_unpack #(.W_DATA(16), .DATA_FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .span_start     (span_start),
        .span_pixmode   (span_pixmode),
        .bus_data_vld   (bus_data_vld),
        .bus_data       (bus_data),
        .pinfo_u        (pinfo_u),
        .pinfo_discard  (pinfo_discard),
        .pinfo_vld      (pinfo_vld),
        .pinfo_rdy      (pinfo_rdy),
        .pixel_data     (pixel_data),
        .pixel_paletted (pixel_paletted),
        .pixel_discard  (pixel_discard),
        .pixel_vld      (pixel_vld),
        .pixel_rdy      (pixel_rdy),
        .idle           (idle)
    );

    always #5 clk = ~clk;

    // Stimulus queues ({discard, u} and halfwords) and collected output
    logic [4:0]  pq[$];
    logic [15:0] bq[$];
    logic [17:0] got[$];
    int          got_cyc[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int first_bus_cyc = -1;
    int fifo_est = 0;
    int rdy_pct = 100;
    int bus_pct = 100;
    bit rdy_force_low = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Expected pixel {discard, paletted, data} straight from the mode rules
    function automatic logic [17:0] model_pixel(input int mode, input int d, input int u, input bit disc);
        int v;
        if (disc) v = 0;
        else begin
            case (mode)
                0:       v = d;
                1:       v = (d >> (8 * (u % 2))) % 256;
                2:       v = (d >> (4 * (u % 4))) % 16;
                default: v = (d >> (u % 16)) % 2;
            endcase
        end
        return {disc, mode != 0, 16'(v)};
    endfunction

    // Bus/AGU driver and output collector
    initial begin : driver
        bit          acc_pinfo;
        bit          acc_disc;
        logic [4:0]  tmp5;
        pinfo_vld     = 1'b0;
        pinfo_u       = 4'd0;
        pinfo_discard = 1'b0;
        bus_data_vld  = 1'b0;
        bus_data      = 16'd0;
        pixel_rdy     = 1'b1;
        forever begin
            @(negedge clk);
            acc_pinfo = pinfo_vld && pinfo_rdy && rst_n;
            acc_disc  = pinfo_discard;
            if (pixel_vld && pixel_rdy && rst_n) begin
                got.push_back({pixel_discard, pixel_paletted, pixel_data});
                got_cyc.push_back(cyc);
            end
            @(posedge clk);
            #1;
            if (!rst_n) begin
                pq.delete();
                bq.delete();
                fifo_est      = 0;
                pinfo_vld     = 1'b0;
                pinfo_discard = 1'b0;
                bus_data_vld  = 1'b0;
            end else begin
                if (acc_pinfo && pq.size() > 0) begin
                    tmp5 = pq.pop_front();
                    if (!acc_disc) fifo_est--;
                end
                if (pq.size() > 0) begin
                    pinfo_vld = 1'b1;
                    {pinfo_discard, pinfo_u} = pq[0];
                end else begin
                    pinfo_vld     = 1'b0;
                    pinfo_discard = 1'b0;
                    pinfo_u       = 4'($urandom);
                end
                if (bq.size() > 0 && fifo_est < DEPTH && $urandom_range(99) < bus_pct) begin
                    bus_data_vld = 1'b1;
                    bus_data     = bq.pop_front();
                    fifo_est++;
                    if (first_bus_cyc < 0) first_bus_cyc = cyc;
                end else begin
                    bus_data_vld = 1'b0;
                    bus_data     = 16'($urandom);
                end
                pixel_rdy = !rdy_force_low && ($urandom_range(99) < rdy_pct);
            end
        end
    end

    task automatic set_mode(input int m);
        for (int i = 0; i < 500 && !(idle && pq.size() == 0 && bq.size() == 0); i++) begin
            @(posedge clk);
            #1;
        end
        span_start   = 1'b1;
        span_pixmode = 2'(m);
        @(posedge clk);
        #1;
        span_start   = 1'b0;
        got.delete();
        got_cyc.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        span_start = 1'b0;
        span_pixmode = 2'd0;
        #2;
        checks++;
        if (pixel_vld !== 1'b0 || pixel_data !== 16'h0 || pixel_paletted !== 1'b0 || pixel_discard !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got vld=%b data=%h pal=%b disc=%b expected all zero",
                     pixel_vld, pixel_data, pixel_paletted, pixel_discard);
        end
        checks++;
        if (idle !== 1'b1 || pinfo_rdy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_rdy: got idle=%b pinfo_rdy=%b expected 1 0", idle, pinfo_rdy);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        // Pixmode must come out of reset as ARGB1555
        got.delete();
        got_cyc.delete();
        @(negedge clk);
        pq.push_back({1'b0, 4'd1});
        bq.push_back(16'hBEEF);
        for (int i = 0; i < 50 && got.size() < 1; i++) @(posedge clk);
        checks++;
        if (got.size() != 1) begin
            errors++;
            $display("FAIL reset_pixmode_count: got %0d pixels expected 1", got.size());
        end else if (got[0] !== {2'b00, 16'hBEEF}) begin
            errors++;
            $display("FAIL reset_pixmode: got %h expected %h", got[0], {2'b00, 16'hBEEF});
        end
    endtask

    task automatic test_mode0_stream();
        logic [15:0] w[4];
        w[0] = 16'h8421; w[1] = 16'h7FFF; w[2] = 16'h0001; w[3] = 16'hFFFF;
        rdy_pct = 100;
        bus_pct = 100;
        set_mode(0);
        first_bus_cyc = -1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            pq.push_back({1'b0, 4'(i)});
            bq.push_back(w[i]);
        end
        for (int i = 0; i < 100 && got.size() < 4; i++) @(posedge clk);
        checks++;
        if (got.size() != 4) begin
            errors++;
            $display("FAIL mode0_count: got %0d pixels expected 4", got.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got[i] !== {2'b00, w[i]}) begin
                    errors++;
                    $display("FAIL mode0_pixel[%0d]: got %h expected %h", i, got[i], {2'b00, w[i]});
                end
            end
            checks++;
            if (got_cyc[0] - first_bus_cyc != 2) begin
                errors++;
                $display("FAIL mode0_latency: got %0d cycles expected 2", got_cyc[0] - first_bus_cyc);
            end
            checks++;
            if (got_cyc[3] - got_cyc[0] != 3) begin
                errors++;
                $display("FAIL mode0_throughput: got %0d cycles for 4 pixels expected 3", got_cyc[3] - got_cyc[0]);
            end
        end
    endtask

    task automatic test_mode2_nibble();
        logic [15:0] e[4];
        e[0] = 16'h000D; e[1] = 16'h000C; e[2] = 16'h000B; e[3] = 16'h000A;
        set_mode(2);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            pq.push_back({1'b0, 4'(i)});
            bq.push_back(16'hABCD);
        end
        for (int i = 0; i < 100 && got.size() < 4; i++) @(posedge clk);
        checks++;
        if (got.size() != 4) begin
            errors++;
            $display("FAIL mode2_count: got %0d pixels expected 4", got.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got[i] !== {2'b01, e[i]}) begin
                    errors++;
                    $display("FAIL mode2_u%0d: got %h expected %h", i, got[i], {2'b01, e[i]});
                end
            end
        end
    endtask

    task automatic test_mode3_mode1();
        set_mode(3);
        @(negedge clk);
        pq.push_back({1'b0, 4'd15});
        bq.push_back(16'h8001);
        pq.push_back({1'b0, 4'd1});
        bq.push_back(16'h8001);
        for (int i = 0; i < 100 && got.size() < 2; i++) @(posedge clk);
        checks++;
        if (got.size() != 2) begin
            errors++;
            $display("FAIL mode3_count: got %0d pixels expected 2", got.size());
        end else begin
            checks++;
            if (got[0] !== {2'b01, 16'h0001}) begin
                errors++;
                $display("FAIL mode3_u15: got %h expected %h", got[0], {2'b01, 16'h0001});
            end
            checks++;
            if (got[1] !== {2'b01, 16'h0000}) begin
                errors++;
                $display("FAIL mode3_u1: got %h expected %h", got[1], {2'b01, 16'h0000});
            end
        end
        set_mode(1);
        @(negedge clk);
        pq.push_back({1'b0, 4'd1});
        bq.push_back(16'h12F0);
        pq.push_back({1'b0, 4'd0});
        bq.push_back(16'h12F0);
        for (int i = 0; i < 100 && got.size() < 2; i++) @(posedge clk);
        checks++;
        if (got.size() != 2) begin
            errors++;
            $display("FAIL mode1_count: got %0d pixels expected 2", got.size());
        end else begin
            checks++;
            if (got[0] !== {2'b01, 16'h0012}) begin
                errors++;
                $display("FAIL mode1_u1: got %h expected %h", got[0], {2'b01, 16'h0012});
            end
            checks++;
            if (got[1] !== {2'b01, 16'h00F0}) begin
                errors++;
                $display("FAIL mode1_u0: got %h expected %h", got[1], {2'b01, 16'h00F0});
            end
        end
    endtask

    task automatic test_discard_interleave();
        logic [17:0] e[3];
        e[0] = {2'b10, 16'h0000}; e[1] = {2'b00, 16'h1234}; e[2] = {2'b10, 16'h0000};
        set_mode(0);
        @(negedge clk);
        pq.push_back({1'b1, 4'd0});
        pq.push_back({1'b0, 4'd0});
        pq.push_back({1'b1, 4'd0});
        bq.push_back(16'h1234);
        for (int i = 0; i < 100 && got.size() < 3; i++) @(posedge clk);
        checks++;
        if (got.size() != 3) begin
            errors++;
            $display("FAIL discard_count: got %0d pixels expected 3", got.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (got[i] !== e[i]) begin
                    errors++;
                    $display("FAIL discard_seq[%0d]: got %h expected %h", i, got[i], e[i]);
                end
            end
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (idle !== 1'b1) begin
            errors++;
            $display("FAIL discard_idle: got idle=%b expected 1", idle);
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] w[4];
        logic [15:0] held;
        bit          seen;
        seen = 1'b0;
        held = 16'h0;
        set_mode(0);
        rdy_force_low = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            w[i] = 16'($urandom);
            pq.push_back({1'b0, 4'(i)});
            bq.push_back(w[i]);
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (pixel_vld) begin
                if (!seen) begin
                    seen = 1'b1;
                    held = pixel_data;
                end else begin
                    checks++;
                    if (pixel_data !== held) begin
                        errors++;
                        $display("FAIL backpressure_stable: got %h expected %h", pixel_data, held);
                    end
                end
            end
        end
        checks++;
        if (!seen || held !== w[0]) begin
            errors++;
            $display("FAIL backpressure_head: got seen=%b data=%h expected 1 %h", seen, held, w[0]);
        end
        rdy_force_low = 1'b0;
        for (int i = 0; i < 100 && got.size() < 4; i++) @(posedge clk);
        checks++;
        if (got.size() != 4) begin
            errors++;
            $display("FAIL backpressure_count: got %0d pixels expected 4", got.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got[i] !== {2'b00, w[i]}) begin
                    errors++;
                    $display("FAIL backpressure_order[%0d]: got %h expected %h", i, got[i], {2'b00, w[i]});
                end
            end
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (idle !== 1'b1) begin
            errors++;
            $display("FAIL backpressure_idle: got idle=%b expected 1", idle);
        end
    endtask

    task automatic test_reset_mid();
        set_mode(0);
        rdy_force_low = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            pq.push_back({1'b0, 4'(i)});
            bq.push_back(16'($urandom));
        end
        for (int i = 0; i < 50 && bq.size() > 0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (pixel_vld !== 1'b1 || idle !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_pre: got vld=%b idle=%b expected 1 0", pixel_vld, idle);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (pixel_vld !== 1'b0 || idle !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_async: got vld=%b idle=%b expected 0 1", pixel_vld, idle);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rdy_force_low = 1'b0;
        got.delete();
        got_cyc.delete();
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (got.size() != 0 || idle !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_stale: got %0d pixels idle=%b expected 0 1", got.size(), idle);
        end
    endtask

    task automatic test_random();
        logic [17:0] exp[$];
        int          m;
        int          n;
        int          u;
        int          d;
        bit          disc;
        rdy_pct = 70;
        bus_pct = 60;
        for (int s = 0; s < 10; s++) begin
            m = $urandom_range(3);
            n = $urandom_range(20, 5);
            set_mode(m);
            exp.delete();
            @(negedge clk);
            for (int k = 0; k < n; k++) begin
                disc = ($urandom_range(3) == 0);
                u    = $urandom_range(15);
                d    = $urandom_range(65535);
                pq.push_back({disc, 4'(u)});
                if (!disc) bq.push_back(16'(d));
                exp.push_back(model_pixel(m, d, u, disc));
            end
            for (int i = 0; i < 2000 && got.size() < n; i++) @(posedge clk);
            checks++;
            if (got.size() != n) begin
                errors++;
                $display("FAIL random_count span %0d: got %0d pixels expected %0d", s, got.size(), n);
            end else begin
                for (int k = 0; k < n; k++) begin
                    checks++;
                    if (got[k] !== exp[k]) begin
                        errors++;
                        $display("FAIL random_pixel span %0d mode %0d [%0d]: got %h expected %h",
                                 s, m, k, got[k], exp[k]);
                    end
                end
            end
        end
        rdy_pct = 100;
        bus_pct = 100;
    endtask

    initial begin
        test_reset();
        test_mode0_stream();
        test_mode2_nibble();
        test_mode3_mode1();
        test_discard_interleave();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/riscboy_ppu_pixel_unpack.md
# riscboy_ppu_pixel_unpack

Pixel unpacker stage of the PPU pixel pipeline, directly downstream of the pixel address generator. It pairs each pixel-metadata entry (`u` low bits, discard flag) from the AGU with the matching halfword returned on the bus data phase. It extracts the addressed pixel according to the span's pixel mode and presents one pixel per handshake to the palette/blend stage. Bus data has no backpressure, so returned halfwords are buffered locally until the output can accept them.

## Interface

Parameters:
- `W_DATA`, 16: bus data width; always a halfword.
- `DATA_FIFO_DEPTH`, 4: returned-data buffer depth. Must be ≥ the AGU's pinfo FIFO depth (4).

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `span_start` in 1: latch `span_pixmode`. Asserted only while `idle` is high.
- `span_pixmode` in 2: 0 = ARGB1555 (16 bpp), 1 = PAL8, 2 = PAL4, 3 = PAL1.
- `bus_data_vld` in 1: a halfword of read data returns this cycle; it cannot be stalled.
- `bus_data` in 16: returned halfword.
- `pinfo_u` in 4: low bits of the pixel `u` coordinate.
- `pinfo_discard` in 1: no bus data exists for this pixel.
- `pinfo_vld` in 1: metadata entry available.
- `pinfo_rdy` out 1: pop the metadata entry.
- `pixel_data` out 16: ARGB1555 colour, or a palette index zero-extended to 16 bits.
- `pixel_paletted` out 1: `pixel_data` holds a palette index.
- `pixel_discard` out 1: transparent pixel; `pixel_data` = 0.
- `pixel_vld` out 1: output pixel valid.
- `pixel_rdy` in 1: downstream accepts.
- `idle` out 1: the data buffer is empty and the output register is empty.

## Operation

- Pixmode register: reset 0; loaded on `span_start`.
- Data FIFO: written on every `bus_data_vld`; popped when a non-discard pixel is unpacked. A write while full is a protocol error, flagged by a simulation assertion; the data is dropped.
- Unpack condition, `take`: `pinfo_vld && (pinfo_discard || !data_empty) && (!pixel_vld || pixel_rdy)`.
  - `pinfo_rdy = take`.
  - Data FIFO pop = `take && !pinfo_discard`.
  - A discard entry never consumes bus data.
- Extraction from FIFO head `d` (`u = pinfo_u`):
  - Mode 0: `pixel_data = d`, `paletted = 0`.
  - Mode 1: `pixel_data = {8'h0, d[8*u[0] +: 8]}`, `paletted = 1`.
  - Mode 2: `pixel_data = {12'h0, d[4*u[1:0] +: 4]}`, `paletted = 1`.
  - Mode 3: `pixel_data = {15'h0, d[u[3:0]]}`, `paletted = 1`.
  - Byte, nibble and bit order are little-endian: the lowest `u` selects the LSBs.
- Discard: `pixel_data = 0`, `pixel_discard = 1`, `pixel_paletted` per mode.
- Output register:
  - Loaded on `take`.
  - `pixel_vld` sets on `take`. It clears on `pixel_rdy && !take`.
  - Output data is held stable while `pixel_vld && !pixel_rdy`.
- Simultaneous events:
  - `bus_data_vld` with an empty FIFO cannot be consumed in the same cycle: no bypass. The halfword is written and is usable the next cycle.
  - A FIFO write and pop in the same cycle while full is legal (level unchanged), because the pop frees the slot first.
  - `span_start` while not idle is illegal; flagged by assertion; behaviour undefined.

## Timing

- Reset values:
  - `pixel_vld = 0`, `pixel_data = 0`, `pixel_paletted = 0`, `pixel_discard = 0`.
  - `pinfo_rdy = 0` while `pinfo_vld = 0`.
  - `idle = 1`, FIFO empty, pixmode = 0.
- Latency:
  - `bus_data_vld` at cycle N → FIFO non-empty at N+1 → `take` at N+1 → `pixel_vld` at N+2.
  - A discard entry at cycle N (output free) → `pixel_vld` at N+1.
- Throughput: one pixel per cycle with `pixel_rdy` held high.
- `pinfo_rdy` is combinational from `pinfo_vld`, FIFO empty, `pixel_vld` and `pixel_rdy`. There is no combinational path from `bus_data_vld` to any output.
- Reset asserted mid-span clears the FIFO and the output register immediately (asynchronously). Buffered pixels are lost. The upstream FIFOs are reset by the same signal.

## Test plan

- Mode 0 streaming: `span_pixmode = 0`; four pinfo entries; data 16'h8421, 16'h7FFF, 16'h0001, 16'hFFFF on consecutive cycles; `pixel_rdy = 1`.
  - Four pixels with the same values, `paletted = 0`, at one per cycle; first pixel 2 cycles after the first data.
- Mode 2 nibble select: data 16'hABCD.
  - `u` = 0, 1, 2, 3 → `pixel_data` = 000D, 000C, 000B, 000A, `paletted = 1`.
- Mode 3 bit select and mode 1 byte select.
  - Mode 3, data 16'h8001: `u = 15` → 1, `u = 1` → 0.
  - Mode 1, data 16'h12F0: `u = 1` → 0012.
- Discard interleave: pinfo discard, u=0, discard; one bus halfword 16'h1234 in mode 0.
  - Output: discard (data 0), then 1234, then discard.
  - Exactly one FIFO pop occurs.
- Backpressure: `pixel_rdy = 0` for 10 cycles while 4 halfwords arrive.
  - No overflow; `pixel_data` is stable throughout.
  - On release, all 4 pixels emerge in order; `idle` is high afterwards.
- Reset mid-operation: assert `rst_n = 0` with 3 halfwords buffered and `pixel_vld = 1`.
  - `pixel_vld = 0` and `idle = 1` immediately; no stale pixel appears after release.
